md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 139 +++++++++++++
 tb/tb_md_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers and a fixed-latency busy window
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rsvalue,
    input  logic [31:0] rtvalue,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDUout,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_safe;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic        [31:0] res_hi, res_lo;
    logic               res_wr, div_ovf, is_div;

    assign start  = !busy_q && (md_op == OP_MULT || md_op == OP_MULTU ||
                                md_op == OP_DIV  || md_op == OP_DIVU);
    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign MDUout = busy_q             ? 32'd0 :
                    (md_op == OP_MFHI) ? hi_q  :
                    (md_op == OP_MFLO) ? lo_q  : 32'd0;

    // Divisor forced nonzero so the datapath never produces X; the write is suppressed instead.
    assign rt_safe = (rtvalue == 32'd0) ? 32'd1 : rtvalue;
    assign prod_s  = $signed({{32{rsvalue[31]}}, rsvalue}) * $signed({{32{rtvalue[31]}}, rtvalue});
    assign prod_u  = {32'd0, rsvalue} * {32'd0, rtvalue};
    assign div_ovf = (rsvalue == 32'h8000_0000) && (rtvalue == 32'hFFFF_FFFF);
    assign quo_s   = $signed(rsvalue) / $signed(rt_safe);
    assign rem_s   = $signed(rsvalue) % $signed(rt_safe);
    assign quo_u   = rsvalue / rt_safe;
    assign rem_u   = rsvalue % rt_safe;
    assign is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (rtvalue == 32'd0) begin
                    res_wr = 1'b0;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                res_wr = (rtvalue != 32'd0);
                res_hi = rem_u;
                res_lo = quo_u;
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (start) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
            cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_d    = 1'b1;
        end else if (md_op == OP_MTHI) begin
            hi_d = rsvalue;
        end else if (md_op == OP_MTLO) begin
            lo_d = rsvalue;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit: busy length and HI/LO checked on each completion
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rsvalue, rtvalue;
    logic        start, busy;
    logic [31:0] MDUout, hi, lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .rsvalue(rsvalue), .rtvalue(rtvalue),
        .start(start), .busy(busy), .MDUout(MDUout), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] ehi;
        logic [31:0] elo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and, when busy falls, pops the next expectation.
    int   run_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run_cnt++;
        end else if (prev_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: busy fell with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_busy_cycles"}, 32'(run_cnt), 32'(e.cyc));
                chk({e.name, "_hi"}, hi, e.ehi);
                chk({e.name, "_lo"}, lo, e.elo);
            end
            run_cnt = 0;
        end
        prev_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string nm, input int cyc, input logic [31:0] eh, input logic [31:0] el);
        md_op = op; rsvalue = a; rtvalue = b;
        #1;
        chk({nm, "_start"}, 32'(start), 32'd1);
        exp_q.push_back('{nm, cyc, eh, el});
        step();
        md_op = 4'd0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%0b still high after %0d cycles", nm, busy, n);
        end
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
        md_op = 4'd5; #1;
        chk({nm, "_mfhi"}, MDUout, eh);
        md_op = 4'd6; #1;
        chk({nm, "_mflo"}, MDUout, el);
        md_op = 4'd0;
    endtask

    initial begin
        reset = 1'b1; md_op = 4'd0; rsvalue = 32'd0; rtvalue = 32'd0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        read_hilo("rst", 32'd0, 32'd0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, "mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_idle("mult");
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3, "multu", 5, 32'h0000_0002, 32'hFFFF_FFFA);
        wait_idle("multu");

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_idle("div");

        issue(4'd4, 32'd7, 32'd2, "divu", 10, 32'd1, 32'd3);
        wait_idle("divu");

        md_op = 4'd7; rsvalue = 32'h1234_5678;
        step();
        md_op = 4'd5; #1;
        chk("mthi_mfhi", MDUout, 32'h1234_5678);
        md_op = 4'd0;

        issue(4'd4, 32'd5, 32'd0, "divu_by0", 10, 32'h1234_5678, 32'd3);
        wait_idle("divu_by0");

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 10, 32'd0, 32'h8000_0000);
        wait_idle("div_ovf");

        // Ops presented while busy are ignored; a held MULT launches the cycle busy falls.
        issue(4'd1, 32'd7, 32'd6, "mult_a", 5, 32'd0, 32'd42);
        md_op = 4'd8; rsvalue = 32'hDEAD_BEEF; #1;
        chk("busy_mtlo_start", 32'(start), 32'd0);
        md_op = 4'd6; #1;
        chk("busy_mflo_out", MDUout, 32'd0);
        md_op = 4'd1; rsvalue = 32'd3; rtvalue = 32'd5; #1;
        chk("busy_mult_start", 32'(start), 32'd0);
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk("b2b_start", 32'(start), 32'd1);
            chk("b2b_lo_new", lo, 32'd42);
            exp_q.push_back('{"mult_b", 5, 32'd0, 32'd15});
            step();
            md_op = 4'd0;
            chk("b2b_busy", 32'(busy), 32'd1);
        end
        wait_idle("mult_b");

        issue(4'd3, 32'd100, 32'd7, "div_abort", 3, 32'd0, 32'd0);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);
        chk("abort_late_busy", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
